// File: rtl/int_ctrl.sv
// Four-line interrupt controller: edge latch, mask, arbitration, and the ack/eoi handshake.
// Define INT_CTRL_ROUND_ROBIN_EN for rotating priority; the default is fixed priority (line 0 highest).
module int_ctrl #(
    parameter int unsigned     AW         = 10,
    parameter logic [AW-1:0]   VEC_BASE   = 10'h3C0,
    parameter logic [AW-1:0]   VEC_STRIDE = 10'd16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    irq,
    input  logic          mask_we,
    input  logic [3:0]    mask_in,
    input  logic          ack,
    input  logic          eoi,
    output logic          int_req,
    output logic [1:0]    int_id,
    output logic [AW-1:0] int_vec,
    output logic [3:0]    pending,
    output logic          in_service
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [3:0]    irq_prev_q, irq_prev_d;
    logic [3:0]    pending_q, pending_d;
    logic [3:0]    mask_q, mask_d;
    logic [1:0]    int_id_q, int_id_d;
    logic [AW-1:0] int_vec_q, int_vec_d;
`ifdef INT_CTRL_ROUND_ROBIN_EN
    logic [1:0]    last_grant_q, last_grant_d;
`endif

    logic [3:0] edges;
    logic [3:0] eligible;
    logic [3:0] clr;
    logic [1:0] start;
    logic [1:0] idx;
    logic [1:0] winner;
    logic       found;

    always_comb begin
        // NOTE: every variable gets a default before any branch so no path leaves it unassigned (no latches).
        edges      = irq & ~irq_prev_q;
        eligible   = pending_q & mask_q;
        clr        = 4'b0000;
        found      = 1'b0;
        winner     = 2'd0;
        idx        = 2'd0;
        state_d    = state_q;
        int_id_d   = int_id_q;
        int_vec_d  = int_vec_q;
        mask_d     = mask_we ? mask_in : mask_q;
        irq_prev_d = irq;
`ifdef INT_CTRL_ROUND_ROBIN_EN
        last_grant_d = last_grant_q;
        start        = last_grant_q + 2'd1;
`else
        start        = 2'd0;
`endif

        // Search from the start slot upward, wrapping 3 -> 0; first eligible line wins.
        for (int k = 0; k < 4; k++) begin
            idx = start + 2'(k);
            if (!found && eligible[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d   = REQ;
                    int_id_d  = winner;
                    int_vec_d = VEC_BASE + AW'(winner) * VEC_STRIDE;
                end
            end
            REQ: begin
                // A latched request is held until ack, even if its mask bit drops.
                if (ack) begin
                    clr[int_id_q] = 1'b1;
                    state_d       = SERVICE;
`ifdef INT_CTRL_ROUND_ROBIN_EN
                    last_grant_d  = int_id_q;
`endif
                end
            end
            SERVICE: begin
                if (eoi) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Set wins over the ack clear when both hit the same line.
        pending_d = (pending_q & ~clr) | edges;
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (reset) begin
            state_q    <= IDLE;
            irq_prev_q <= 4'b0000;
            pending_q  <= 4'b0000;
            mask_q     <= 4'b0000;
            int_id_q   <= 2'd0;
            int_vec_q  <= VEC_BASE;
`ifdef INT_CTRL_ROUND_ROBIN_EN
            last_grant_q <= 2'd3;
`endif
        end else begin
            state_q    <= state_d;
            irq_prev_q <= irq_prev_d;
            pending_q  <= pending_d;
            mask_q     <= mask_d;
            int_id_q   <= int_id_d;
            int_vec_q  <= int_vec_d;
`ifdef INT_CTRL_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign int_req    = (state_q == REQ);
    assign in_service = (state_q == SERVICE);
    assign int_id     = int_id_q;
    assign int_vec    = int_vec_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Bench for int_ctrl: directed scenarios plus random traffic, checked against a behavioural model
// and a grant scoreboard. Honours INT_CTRL_ROUND_ROBIN_EN the same way the design does.
module tb_int_ctrl;

    localparam int S_IDLE = 0;
    localparam int S_REQ  = 1;
    localparam int S_SVC  = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       mask_we;
    logic [3:0] mask_in;
    logic       ack;
    logic       eoi;
    logic       int_req;
    logic [1:0] int_id;
    logic [9:0] int_vec;
    logic [3:0] pending;
    logic       in_service;

    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;
    logic prev_req = 1'b0;

    // Reference model state
    logic [3:0] m_prev = 4'b0000;
    logic [3:0] m_pend = 4'b0000;
    logic [3:0] m_mask = 4'b0000;
    int         m_state = S_IDLE;
    int         m_id = 0;
    int         m_last = 3;
    int         exp_q[$];

    int_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .ack        (ack),
        .eoi        (eoi),
        .int_req    (int_req),
        .int_id     (int_id),
        .int_vec    (int_vec),
        .pending    (pending),
        .in_service (in_service)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [9:0] vec_of(input int id);
        return 10'((960 + id * 16) % 1024);
    endfunction

    function automatic int pick(input logic [3:0] elig, input int last);
        int start;
        start = 0;
`ifdef INT_CTRL_ROUND_ROBIN_EN
        start = (last + 1) % 4;
`endif
        for (int k = 0; k < 4; k++) begin
            if (elig[(start + k) % 4]) return (start + k) % 4;
        end
        return 0;
    endfunction

    task automatic model_step();
        logic [3:0] edges;
        logic [3:0] nxt;
        if (reset) begin
            m_prev  = 4'b0000;
            m_pend  = 4'b0000;
            m_mask  = 4'b0000;
            m_state = S_IDLE;
            m_id    = 0;
            m_last  = 3;
            return;
        end
        edges = irq & ~m_prev;
        nxt   = m_pend;
        case (m_state)
            S_IDLE: begin
                if ((m_pend & m_mask) != 4'b0000) begin
                    m_id    = pick(m_pend & m_mask, m_last);
                    m_state = S_REQ;
                    exp_q.push_back(m_id);
                end
            end
            S_REQ: begin
                if (ack) begin
                    nxt[m_id] = 1'b0;
                    m_last    = m_id;
                    m_state   = S_SVC;
                end
            end
            default: begin
                if (eoi) m_state = S_IDLE;
            end
        endcase
        m_pend = nxt | edges;
        if (mask_we) m_mask = mask_in;
        m_prev = irq;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
        end
    end

    // Monitor: per-cycle status against the model, grants against the scoreboard.
    initial begin
        int e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                check("pending", pending, m_pend);
                check("int_req", int_req, m_state == S_REQ);
                check("in_service", in_service, m_state == S_SVC);
                check("int_id", int_id, m_id);
                check("int_vec", int_vec, vec_of(m_id));
                if (int_req === 1'b1 && prev_req !== 1'b1) begin
                    check("grant_queued", exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("grant_id", int_id, e);
                        check("grant_vec", int_vec, vec_of(e));
                    end
                end
            end
            prev_req = int_req;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic write_mask(input logic [3:0] m);
        mask_we = 1'b1;
        mask_in = m;
        tick();
        mask_we = 1'b0;
    endtask

    task automatic pulse_irq(input logic [3:0] v);
        irq = v;
        tick();
        irq = 4'b0000;
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    task automatic do_eoi();
        eoi = 1'b1;
        tick();
        eoi = 1'b0;
    endtask

    initial begin
        reset = 1'b1; irq = 4'b0000; mask_we = 1'b0; mask_in = 4'b0000; ack = 1'b0; eoi = 1'b0;
        do_reset();
        mon_en = 1'b1;
        check("rst_int_req", int_req, 0);
        check("rst_int_vec", int_vec, 10'h3C0);
        check("rst_pending", pending, 0);

        // Single line, all enabled: 2-cycle edge-to-request latency.
        write_mask(4'b1111);
        pulse_irq(4'b0100);
        check("s1_pending", pending, 4'b0100);
        check("s1_req_early", int_req, 0);
        tick();
        check("s1_req", int_req, 1);
        check("s1_id", int_id, 2);
        check("s1_vec", int_vec, 10'h3E0);
        do_ack();
        check("s1_svc", in_service, 1);
        check("s1_clr", pending, 0);
        do_eoi();
        check("s1_eoi", in_service, 0);

        // Masked pending line is released by a later mask write.
        do_reset();
        pulse_irq(4'b0010);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("s2_masked_pend", pending, 4'b0010);
            check("s2_masked_req", int_req, 0);
        end
        write_mask(4'b0010);
        check("s2_req_1cyc", int_req, 0);
        tick();
        check("s2_req_2cyc", int_req, 1);
        check("s2_id", int_id, 1);
        do_ack();
        do_eoi();

        // Simultaneous edges on lines 3 and 0: line 0 first in both priority modes after reset.
        do_reset();
        write_mask(4'b1111);
        pulse_irq(4'b1001);
        tick();
        check("s3_first", int_id, 0);
        do_ack();
        do_eoi();
        tick();
        check("s3_second", int_id, 3);
        check("s3_second_req", int_req, 1);
        do_ack();
        do_eoi();

        // New edge on line 1 coincides with its ack: pending stays set, second request follows.
        pulse_irq(4'b0010);
        tick();
        check("s4_req", int_id, 1);
        ack = 1'b1;
        irq = 4'b0010;
        tick();
        ack = 1'b0;
        irq = 4'b0000;
        check("s4_set_wins", pending[1], 1);
        do_eoi();
        tick();
        check("s4_rereq", int_req, 1);
        check("s4_rereq_id", int_id, 1);
        do_ack();
        do_eoi();

        // No nesting: an edge during SERVICE waits for eoi plus one IDLE cycle.
        pulse_irq(4'b0100);
        tick();
        do_ack();
        pulse_irq(4'b0001);
        check("s5_pend_in_svc", pending, 4'b0001);
        tick();
        check("s5_no_nest", int_req, 0);
        do_eoi();
        check("s5_idle_gap", int_req, 0);
        tick();
        check("s5_req_after", int_req, 1);
        check("s5_id", int_id, 0);

        // Reset while in REQ, with edges arriving during reset that must be discarded.
        reset = 1'b1;
        tick();
        check("s6_req", int_req, 0);
        check("s6_id", int_id, 0);
        check("s6_vec", int_vec, 10'h3C0);
        check("s6_pend", pending, 0);
        check("s6_svc", in_service, 0);
        irq = 4'b1111;
        tick();
        irq = 4'b0000;
        tick();
        reset = 1'b0;
        tick();
        check("s6_edges_dropped", pending, 0);

        // Random traffic, including out-of-state ack/eoi and occasional resets.
        for (int i = 0; i < 600; i++) begin
            irq     = 4'($urandom_range(0, 15));
            mask_we = ($urandom_range(0, 7) == 0);
            mask_in = 4'($urandom_range(0, 15));
            ack     = ($urandom_range(0, 2) == 0);
            eoi     = ($urandom_range(0, 3) == 0);
            reset   = ($urandom_range(0, 199) == 0);
            tick();
        end
        irq = 4'b0000; mask_we = 1'b0; ack = 1'b0; eoi = 1'b0; reset = 1'b0;
        tick();
        tick();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
